mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters:
  - the multi-cycle CPU controller (fetch, operand read, operand write);
  - a DMA/debug loader port.
- Sits between both masters and the memory macro.
- Serialises accesses, inserts the memory's fixed wait states and returns read data with a one-cycle acknowledge.
- The CPU controller holds its current state while its request is unacknowledged.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_arb_rr2.sv | 22 ++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ACK
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int unsigned CNT_W = 4;
endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Combinational 2-way picker: round-robin on ties, or fixed CPU priority
// when CPU_PRIORITY_EN is defined.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       grant_id_o
);
    always_comb begin
        grant_id_o = OWN_CPU;
        if (req_i == 2'b10) begin
            grant_id_o = OWN_DMA;
        end else if (req_i == 2'b11) begin
`ifdef CPU_PRIORITY_EN
            grant_id_o = OWN_CPU;
`else
            grant_id_o = ~last_owner_i;
`endif
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses onto the single-port memory with MEM_LAT
// wait cycles and a one-cycle ack. Optional macro: CPU_PRIORITY_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_gnt,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic              cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic              grant_id;
    logic              sel_dma;

    arb_rr2 u_arb (
        .req_i        ({dma_req, cpu_req}),
        .last_owner_i (last_owner_q),
        .grant_id_o   (grant_id)
    );

    assign sel_dma = (grant_id == OWN_DMA);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = cpu_ack_q;
        dma_ack_d    = dma_ack_q;
        cpu_gnt_d    = cpu_gnt_q;
        dma_gnt_d    = dma_gnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d      = owner_e'(grant_id);
                    last_owner_d = owner_e'(grant_id);
                    mem_en_d     = 1'b1;
                    mem_we_d     = sel_dma ? dma_we    : cpu_we;
                    mem_addr_d   = sel_dma ? dma_addr  : cpu_addr;
                    mem_wdata_d  = sel_dma ? dma_wdata : cpu_wdata;
                    cpu_gnt_d    = ~sel_dma;
                    dma_gnt_d    = sel_dma;
                    cnt_d        = CNT_W'(MEM_LAT - 1);
                    state_d      = ACC;
                end
            end
            ACC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // mem_rdata is valid at the end of the last enable cycle
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ACK;
                    if (owner_q == OWN_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (!mem_we_q) cpu_rdata_d = mem_rdata;
                    end else begin
                        dma_ack_d = 1'b1;
                        if (!mem_we_q) dma_rdata_d = mem_rdata;
                    end
                end
            end
            ACK: begin
                cpu_ack_d   = 1'b0;
                dma_ack_d   = 1'b0;
                cpu_gnt_d   = 1'b0;
                dma_gnt_d   = 1'b0;
                cpu_rdata_d = '0;
                dma_rdata_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DMA;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dma_gnt_q    <= dma_gnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_gnt   = cpu_gnt_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_gnt   = dma_gnt_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) against an
// access-timeline reference model; directed cases then random traffic.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // [instance][master], master 0 = CPU, 1 = DMA
    logic        req_s   [2][2];
    logic        we_s    [2][2];
    logic [11:0] addr_s  [2][2];
    logic [11:0] wdata_s [2][2];
    logic        ack_s   [2][2];
    logic        gnt_s   [2][2];
    logic [11:0] rdata_s [2][2];
    logic        men_s   [2];
    logic        mwe_s   [2];
    logic [11:0] maddr_s [2];
    logic [11:0] mwdata_s[2];
    logic [11:0] mrd0, mrd1;
    logic [11:0] tbmem   [2][4096];

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(req_s[0][0]), .cpu_we(we_s[0][0]), .cpu_addr(addr_s[0][0]),
        .cpu_wdata(wdata_s[0][0]), .cpu_rdata(rdata_s[0][0]), .cpu_ack(ack_s[0][0]),
        .cpu_gnt(gnt_s[0][0]),
        .dma_req(req_s[0][1]), .dma_we(we_s[0][1]), .dma_addr(addr_s[0][1]),
        .dma_wdata(wdata_s[0][1]), .dma_rdata(rdata_s[0][1]), .dma_ack(ack_s[0][1]),
        .dma_gnt(gnt_s[0][1]),
        .mem_en(men_s[0]), .mem_we(mwe_s[0]), .mem_addr(maddr_s[0]),
        .mem_wdata(mwdata_s[0]), .mem_rdata(mrd0)
    );

    mem_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(req_s[1][0]), .cpu_we(we_s[1][0]), .cpu_addr(addr_s[1][0]),
        .cpu_wdata(wdata_s[1][0]), .cpu_rdata(rdata_s[1][0]), .cpu_ack(ack_s[1][0]),
        .cpu_gnt(gnt_s[1][0]),
        .dma_req(req_s[1][1]), .dma_we(we_s[1][1]), .dma_addr(addr_s[1][1]),
        .dma_wdata(wdata_s[1][1]), .dma_rdata(rdata_s[1][1]), .dma_ack(ack_s[1][1]),
        .dma_gnt(gnt_s[1][1]),
        .mem_en(men_s[1]), .mem_we(mwe_s[1]), .mem_addr(maddr_s[1]),
        .mem_wdata(mwdata_s[1]), .mem_rdata(mrd1)
    );

    function automatic logic [11:0] init_word(input int a);
        if (a == 5) return 12'hA3C;
        return 12'(a * 37) ^ 12'h2C1;
    endfunction

    function automatic int unsigned lat_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Memory macro stand-ins: write on every enabled write cycle, async read.
    assign mrd0 = tbmem[0][maddr_s[0]];
    assign mrd1 = tbmem[1][maddr_s[1]];
    initial begin
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 4096; a++) tbmem[i][a] = init_word(a);
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++)
                if (men_s[i] && mwe_s[i]) tbmem[i][maddr_s[i]] = mwdata_s[i];
        end
    end

    // Reference model: one access occupies a slot of lat+2 cycles; m_d counts
    // cycles since the granting edge.
    bit          m_busy [2];
    int unsigned m_d    [2];
    int          m_own  [2];
    bit          m_we   [2];
    logic [11:0] m_addr [2];
    logic [11:0] m_wdata[2];
    int          m_last [2];
    int          m_w;
    bit          m_loaded = 1'b0;
    logic [11:0] shadow [2][4096];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            if (!m_loaded) begin
                for (int i = 0; i < 2; i++)
                    for (int a = 0; a < 4096; a++) shadow[i][a] = init_word(a);
                m_loaded = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0; m_d[i] = 0; m_own[i] = 0; m_we[i] = 1'b0; m_last[i] = 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i] && m_d[i] <= lat_of(i)) begin
                    if (m_d[i] == 0 && m_we[i]) shadow[i][m_addr[i]] = m_wdata[i];
                    m_d[i]++;
                end else begin
                    m_busy[i] = 1'b0;
                    if (req_s[i][0] || req_s[i][1]) begin
                        if (req_s[i][0] && req_s[i][1]) begin
`ifdef CPU_PRIORITY_EN
                            m_w = 0;
`else
                            m_w = 1 - m_last[i];
`endif
                        end else begin
                            m_w = req_s[i][0] ? 0 : 1;
                        end
                        m_busy[i]  = 1'b1;
                        m_d[i]     = 0;
                        m_own[i]   = m_w;
                        m_last[i]  = m_w;
                        m_we[i]    = we_s[i][m_w];
                        m_addr[i]  = addr_s[i][m_w];
                        m_wdata[i] = wdata_s[i][m_w];
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int cyc = 0;
    int gcnt [2][2];
    int acnt [2][2];
    int wecnt[2];
    int encnt[2];
    bit gprev[2][2];
    bit eprev0 = 1'b0;
    int q_own[$];
    int q_start[$];
    int hc[2][2];

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int unsigned lat = lat_of(i);
            bit en = m_busy[i] && (m_d[i] < lat);
            bit ak = m_busy[i] && (m_d[i] == lat);
            bit gn = m_busy[i] && (m_d[i] <= lat);
            chk($sformatf("i%0d.mem_en", i), 32'(men_s[i]), 32'(en));
            chk($sformatf("i%0d.mem_we", i), 32'(mwe_s[i]), 32'(en && m_we[i]));
            if (en) begin
                chk($sformatf("i%0d.mem_addr", i), 32'(maddr_s[i]), 32'(m_addr[i]));
                chk($sformatf("i%0d.mem_wdata", i), 32'(mwdata_s[i]), 32'(m_wdata[i]));
            end
            for (int m = 0; m < 2; m++) begin
                bit mine = (m_own[i] == m);
                logic [11:0] erd = (ak && mine && !m_we[i]) ? shadow[i][m_addr[i]] : 12'h000;
                chk($sformatf("i%0d.m%0d.ack", i, m), 32'(ack_s[i][m]), 32'(ak && mine));
                chk($sformatf("i%0d.m%0d.gnt", i, m), 32'(gnt_s[i][m]), 32'(gn && mine));
                chk($sformatf("i%0d.m%0d.rdata", i, m), 32'(rdata_s[i][m]), 32'(erd));
                if (gnt_s[i][m] && !gprev[i][m]) begin
                    gcnt[i][m]++;
                    if (i == 0) q_own.push_back(m);
                end
                gprev[i][m] = gnt_s[i][m];
                if (ack_s[i][m]) acnt[i][m]++;
            end
            if (mwe_s[i]) wecnt[i]++;
            if (men_s[i]) encnt[i]++;
        end
        if (men_s[0] && !eprev0) q_start.push_back(cyc);
        eprev0 = men_s[0];
    endtask

    task automatic access(input int i, input int m, input logic we, input logic [11:0] a,
                          input logic [11:0] wd, input int hold,
                          output logic [11:0] rd, output int k_ack);
        bit got = 1'b0;
        rd = '0;
        k_ack = 0;
        req_s[i][m] = 1'b1; we_s[i][m] = we; addr_s[i][m] = a; wdata_s[i][m] = wd;
        for (int k = 1; k <= 40 && !got; k++) begin
            tick();
            if (ack_s[i][m]) begin
                got = 1'b1; rd = rdata_s[i][m]; k_ack = k;
            end
        end
        chk($sformatf("i%0d.m%0d.ack_seen", i, m), 32'(got), 32'd1);
        for (int h = 0; h < hold; h++) tick();
        req_s[i][m] = 1'b0;
    endtask

    initial begin
        logic [11:0] rd;
        int          k;
        bit          seen;
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                req_s[i][m] = 1'b0; we_s[i][m] = 1'b0; addr_s[i][m] = '0; wdata_s[i][m] = '0;
                gcnt[i][m] = 0; acnt[i][m] = 0; gprev[i][m] = 1'b0; hc[i][m] = 0;
            end
            wecnt[i] = 0; encnt[i] = 0;
        end
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // CPU read of preloaded 0x005
        encnt[0] = 0;
        access(0, 0, 1'b0, 12'h005, 12'h000, 0, rd, k);
        chk("cpu_rd_a3c", 32'(rd), 32'h0000_0A3C);
        chk("cpu_rd_latency", 32'(k), 32'd3);
        chk("cpu_rd_en_cycles", 32'(encnt[0]), 32'd2);
        chk("cpu_rd_no_dma_ack", 32'(acnt[0][1]), 32'd0);

        // DMA write then CPU read-back
        wecnt[0] = 0;
        access(0, 1, 1'b1, 12'h010, 12'h7FF, 0, rd, k);
        chk("dma_wr_we_cycles", 32'(wecnt[0]), 32'd2);
        access(0, 0, 1'b0, 12'h010, 12'h000, 0, rd, k);
        chk("cpu_rd_7ff", 32'(rd), 32'h0000_07FF);

        // Stale request held through ACK only vs. still high in IDLE
        repeat (3) tick();
        gcnt[0][0] = 0;
        access(0, 0, 1'b0, 12'h003, 12'h000, 1, rd, k);
        repeat (5) tick();
        chk("stale_ack_no_regrant", 32'(gcnt[0][0]), 32'd1);
        gcnt[0][0] = 0;
        access(0, 0, 1'b0, 12'h003, 12'h000, 2, rd, k);
        repeat (6) tick();
        chk("held_to_idle_regrant", 32'(gcnt[0][0]), 32'd2);

        // Reset during the second ACC cycle of a CPU write
        req_s[0][0] = 1'b1; we_s[0][0] = 1'b1; addr_s[0][0] = 12'h020; wdata_s[0][0] = 12'h155;
        seen = 1'b0;
        for (int j = 0; j < 10 && !seen; j++) begin
            tick();
            seen = men_s[0];
        end
        chk("rst_setup_en", 32'(seen), 32'd1);
        acnt[0][0] = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_s[0][1] = 1'b1; we_s[0][1] = 1'b0; addr_s[0][1] = 12'h021;
        #1;
        chk("rst_mem_we_async", 32'(mwe_s[0]), 32'd0);
        chk("rst_mem_en_async", 32'(men_s[0]), 32'd0);
        chk("rst_cpu_gnt_async", 32'(gnt_s[0][0]), 32'd0);
        q_own.delete();
        q_start.delete();
        tick();
        tick();
        chk("rst_no_ack", 32'(acnt[0][0]), 32'd0);

        // Both requesters held from reset release: tie order and spacing
        rst = 1'b0;
        repeat (16) tick();
        chk("tie_grant_count", 32'(q_own.size()), 32'd4);
        chk("tie_start_count", 32'(q_start.size()), 32'd4);
        for (int j = 0; j < 4 && j < q_own.size(); j++) begin
`ifdef CPU_PRIORITY_EN
            chk($sformatf("tie_owner%0d", j), 32'(q_own[j]), 32'd0);
`else
            chk($sformatf("tie_owner%0d", j), 32'(q_own[j]), 32'(j % 2));
`endif
        end
        for (int j = 1; j < 4 && j < q_start.size(); j++)
            chk($sformatf("tie_spacing%0d", j), 32'(q_start[j] - q_start[j-1]), 32'd4);
        req_s[0][0] = 1'b0;
        req_s[0][1] = 1'b0;
        repeat (6) tick();

        // Random traffic on both instances
        repeat (2000) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                for (int m = 0; m < 2; m++) begin
                    if (ack_s[i][m]) begin
                        hc[i][m] = int'($urandom_range(0, 2));
                        if (hc[i][m] == 0) req_s[i][m] = 1'b0;
                    end else if (hc[i][m] > 0) begin
                        hc[i][m]--;
                        if (hc[i][m] == 0) req_s[i][m] = 1'b0;
                    end else if (!req_s[i][m]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            req_s[i][m]   = 1'b1;
                            we_s[i][m]    = 1'($urandom_range(0, 1));
                            addr_s[i][m]  = 12'($urandom_range(0, 15));
                            wdata_s[i][m] = 12'($urandom);
                        end
                    end else if ($urandom_range(0, 49) == 0) begin
                        req_s[i][m] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++) req_s[i][m] = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
